// File: rtl/operand_dispatch.sv
// rtl/operand_dispatch.sv - rs1/rs2 operand dispatcher into NUM_UNITS per-unit FIFO channels
// Optional perf counters (disp_cnt, drop_cnt) enabled by defining OPERAND_DISPATCH_PERF_EN.
module operand_dispatch #(
    parameter int WIDTH     = 16,
    parameter int NUM_UNITS = 4,
    parameter int SEL_W     = 2,
    parameter int DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic [WIDTH-1:0]           in_rs1,
    input  logic [WIDTH-1:0]           in_rs2,
    output logic [NUM_UNITS-1:0]       out_valid,
    input  logic [NUM_UNITS-1:0]       out_ready,
    output logic [NUM_UNITS*WIDTH-1:0] out_rs1,
    output logic [NUM_UNITS*WIDTH-1:0] out_rs2,
    output logic                       illegal
`ifdef OPERAND_DISPATCH_PERF_EN
    ,
    output logic [NUM_UNITS*16-1:0]    disp_cnt,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [SEL_W:0] NUM_SEL = (SEL_W+1)'(NUM_UNITS);

    logic [SEL_W:0]       sel_ext;
    logic                 sel_legal;
    logic [NUM_UNITS-1:0] sel_hit;
    logic [NUM_UNITS-1:0] full;
    logic [NUM_UNITS-1:0] push;
    logic                 accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Extra MSB lets the legality compare work even when 2**SEL_W == NUM_UNITS.
    assign sel_ext   = {1'b0, in_sel};
    assign sel_legal = sel_ext < NUM_SEL;

    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            sel_hit[i] = (sel_ext == (SEL_W+1)'(i));
        end
    end

    // Only the occupancy count feeds in_ready; a pop in the same cycle never frees a full slot early.
    assign in_ready = sel_legal ? ~|(sel_hit & full) : 1'b1;
    assign accept   = in_valid && in_ready;
    assign push     = accept ? sel_hit : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else begin
            illegal <= accept && !sel_legal;
        end
    end

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_ch
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
        logic [WIDTH-1:0] mem_rs1 [DEPTH];
        logic [WIDTH-1:0] mem_rs2 [DEPTH];
        logic [WIDTH-1:0] last_rs1;
        logic [WIDTH-1:0] last_rs2;
        logic             pop;

        assign out_valid[g] = (count != '0);
        assign full[g]      = (count == CNT_W'(DEPTH));
        assign pop          = out_valid[g] && out_ready[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                last_rs1 <= '0;
                last_rs2 <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr   <= ptr_inc(rd_ptr);
                    last_rs1 <= mem_rs1[rd_ptr];
                    last_rs2 <= mem_rs2[rd_ptr];
                end
                if (push[g] && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push[g]) begin
                    count <= count - CNT_W'(1);
                end
            end
        end

        // Storage needs no reset: it is only visible while count is non-zero.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem_rs1[wr_ptr] <= in_rs1;
                mem_rs2[wr_ptr] <= in_rs2;
            end
        end

        assign out_rs1[g*WIDTH +: WIDTH] = out_valid[g] ? mem_rs1[rd_ptr] : last_rs1;
        assign out_rs2[g*WIDTH +: WIDTH] = out_valid[g] ? mem_rs2[rd_ptr] : last_rs2;

`ifdef OPERAND_DISPATCH_PERF_EN
        logic [15:0] push_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                push_cnt <= '0;
            end else if (push[g] && push_cnt != 16'hFFFF) begin
                push_cnt <= push_cnt + 16'd1;
            end
        end

        assign disp_cnt[g*16 +: 16] = push_cnt;
`endif
    end

`ifdef OPERAND_DISPATCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && !sel_legal && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_dispatch.sv
// tb/tb_operand_dispatch.sv - scoreboard bench for operand_dispatch (4-unit and 3-unit instances)
module tb_operand_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [15:0] in_rs1, in_rs2;
    logic [3:0]  out_valid, out_ready;
    logic [63:0] out_rs1, out_rs2;
    logic        illegal;

    logic        u3_in_valid, u3_in_ready;
    logic [1:0]  u3_in_sel;
    logic [15:0] u3_in_rs1, u3_in_rs2;
    logic [2:0]  u3_out_valid, u3_out_ready;
    logic [47:0] u3_out_rs1, u3_out_rs2;
    logic        u3_illegal;
`ifdef OPERAND_DISPATCH_PERF_EN
    logic [63:0] disp_cnt;
    logic [15:0] drop_cnt;
    logic [47:0] u3_disp_cnt;
    logic [15:0] u3_drop_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] sbq [4][$];

    always #5 clk = ~clk;

    operand_dispatch #(.WIDTH(16), .NUM_UNITS(4), .SEL_W(2), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .illegal(illegal)
`ifdef OPERAND_DISPATCH_PERF_EN
        , .disp_cnt(disp_cnt), .drop_cnt(drop_cnt)
`endif
    );

    operand_dispatch #(.WIDTH(16), .NUM_UNITS(3), .SEL_W(2), .DEPTH(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(u3_in_valid), .in_ready(u3_in_ready), .in_sel(u3_in_sel),
        .in_rs1(u3_in_rs1), .in_rs2(u3_in_rs2), .out_valid(u3_out_valid), .out_ready(u3_out_ready),
        .out_rs1(u3_out_rs1), .out_rs2(u3_out_rs2), .illegal(u3_illegal)
`ifdef OPERAND_DISPATCH_PERF_EN
        , .disp_cnt(u3_disp_cnt), .drop_cnt(u3_drop_cnt)
`endif
    );

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] a, input logic [15:0] b);
        in_valid = v;
        in_sel   = s;
        in_rs1   = a;
        in_rs2   = b;
    endtask

    // Monitor: every handshake on a channel pops and compares the oldest expected pair.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 4; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    if (sbq[c].size() == 0) begin
                        check("unexpected_pop", {32'd0, out_rs2[c*16 +: 16], out_rs1[c*16 +: 16]}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("sb_data", {32'd0, out_rs2[c*16 +: 16], out_rs1[c*16 +: 16]}, {32'd0, sbq[c].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        int budget;
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 16'h0, 16'h0);
        out_ready    = '0;
        u3_in_valid  = 1'b0;
        u3_in_sel    = '0;
        u3_in_rs1    = '0;
        u3_in_rs2    = '0;
        u3_out_ready = '0;
        step();
        step();
        @(negedge clk);
        check("reset_out_valid", {60'd0, out_valid}, 64'd0);
        check("reset_out_rs1", out_rs1, 64'd0);
        check("reset_illegal", {63'd0, illegal}, 64'd0);
        rst_n = 1'b1;

        // Single entry on channel 0, held until consumed
        step();
        drive(1'b1, 2'd0, 16'h1234, 16'h0001);
        @(negedge clk);
        check("t1_in_ready", {63'd0, in_ready}, 64'd1);
        sbq[0].push_back({16'h0001, 16'h1234});
        step();
        drive(1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        check("t1_out_valid", {60'd0, out_valid}, 64'h1);
        check("t1_out_rs1", {48'd0, out_rs1[15:0]}, 64'h1234);
        step();
        step();
        @(negedge clk);
        check("t1_held", {60'd0, out_valid}, 64'h1);
        step();
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check("t1_popped", {60'd0, out_valid}, 64'h0);
        check("t1_rs1_holds_last", {48'd0, out_rs1[15:0]}, 64'h1234);

        // Fill channel 2, back-pressure per channel, drain in order
        step();
        drive(1'b1, 2'd2, 16'hAAAA, 16'hA0A0);
        @(negedge clk);
        check("t2_push_a", {63'd0, in_ready}, 64'd1);
        sbq[2].push_back({16'hA0A0, 16'hAAAA});
        step();
        drive(1'b1, 2'd2, 16'hBBBB, 16'hB0B0);
        @(negedge clk);
        check("t2_push_b", {63'd0, in_ready}, 64'd1);
        sbq[2].push_back({16'hB0B0, 16'hBBBB});
        step();
        drive(1'b1, 2'd2, 16'hCCCC, 16'hC0C0);
        @(negedge clk);
        check("t2_full_stall", {63'd0, in_ready}, 64'd0);
        step();
        drive(1'b0, 2'd1, 16'h0, 16'h0);
        @(negedge clk);
        check("t2_other_ready", {63'd0, in_ready}, 64'd1);
        step();
        in_sel    = 2'd2;
        out_ready = 4'b0100;
        @(negedge clk);
        check("t2_full_while_pop", {63'd0, in_ready}, 64'd0);
        step();
        step();
        out_ready = 4'b0000;
        @(negedge clk);
        check("t2_drained", {60'd0, out_valid}, 64'h0);

        // Streaming through channel 3 with pointer wrap
        out_ready = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            step();
            drive(1'b1, 2'd3, 16'h3000 + 16'(k), 16'h0300 + 16'(k));
            @(negedge clk);
            check("t3_in_ready", {63'd0, in_ready}, 64'd1);
            if (k > 0) check("t3_valid", {63'd0, out_valid[3]}, 64'd1);
            sbq[3].push_back({16'h0300 + 16'(k), 16'h3000 + 16'(k)});
        end
        step();
        drive(1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        check("t3_last_valid", {63'd0, out_valid[3]}, 64'd1);
        step();
        @(negedge clk);
        check("t3_empty", {63'd0, out_valid[3]}, 64'd0);
        out_ready = 4'b0000;

        // Illegal select on the 3-unit instance
        step();
        u3_in_valid = 1'b1;
        u3_in_sel   = 2'd3;
        u3_in_rs1   = 16'hDEAD;
        @(negedge clk);
        check("t4_ready_illegal", {63'd0, u3_in_ready}, 64'd1);
        check("t4_no_early_pulse", {63'd0, u3_illegal}, 64'd0);
        step();
        u3_in_valid = 1'b0;
        @(negedge clk);
        check("t4_illegal_pulse", {63'd0, u3_illegal}, 64'd1);
        check("t4_no_valid", {61'd0, u3_out_valid}, 64'd0);
`ifdef OPERAND_DISPATCH_PERF_EN
        check("t4_drop_cnt", {48'd0, u3_drop_cnt}, 64'd1);
        check("t4_disp_cnt", {16'd0, u3_disp_cnt}, 64'd0);
`endif
        step();
        @(negedge clk);
        check("t4_pulse_ends", {63'd0, u3_illegal}, 64'd0);
        check("t4_still_empty", {61'd0, u3_out_valid}, 64'd0);
        step();
        u3_in_valid = 1'b1;
        u3_in_sel   = 2'd2;
        u3_in_rs1   = 16'hABCD;
        step();
        u3_in_valid = 1'b0;
        @(negedge clk);
        check("t4_legal_valid", {61'd0, u3_out_valid}, 64'h4);
        check("t4_legal_rs1", {48'd0, u3_out_rs1[47:32]}, 64'hABCD);
        check("t4_legal_no_illegal", {63'd0, u3_illegal}, 64'd0);

        // Fill channels 0 and 1, then asynchronous reset mid-cycle
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b1, (k < 2) ? 2'd0 : 2'd1, 16'h5000 + 16'(k), 16'h0500 + 16'(k));
            @(negedge clk);
            check("t5_fill", {63'd0, in_ready}, 64'd1);
        end
        step();
        drive(1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        check("t5_full", {60'd0, out_valid}, 64'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_reset", {60'd0, out_valid}, 64'h0);
        check("t5_async_rs1", out_rs1, 64'd0);
        for (int c = 0; c < 4; c++) sbq[c].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready_after", {63'd0, in_ready}, 64'd1);

`ifdef OPERAND_DISPATCH_PERF_EN
        out_ready = 4'b0010;
        for (int k = 0; k < 70000; k++) begin
            step();
            drive(1'b1, 2'd1, 16'(k), ~16'(k));
            sbq[1].push_back({~16'(k), 16'(k)});
        end
        step();
        drive(1'b0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        check("perf_ch1_sat", {48'd0, disp_cnt[31:16]}, 64'hFFFF);
        check("perf_others", {16'd0, disp_cnt[63:32], disp_cnt[15:0]}, 64'd0);
        check("perf_drop_zero", {48'd0, drop_cnt}, 64'd0);
`endif

        step();
        drive(1'b1, 2'd0, 16'h7777, 16'h0707);
        @(negedge clk);
        check("t5_push_after", {63'd0, in_ready}, 64'd1);
        sbq[0].push_back({16'h0707, 16'h7777});
        step();
        drive(1'b0, 2'd0, 16'h0, 16'h0);

        // Drain everything and confirm the scoreboard empties
        out_ready = 4'b1111;
        budget = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && budget < 50) begin
            step();
            budget++;
        end
        @(negedge clk);
        check("sb_empty", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 64'd0);
        check("final_out_valid", {60'd0, out_valid}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
